// File: rtl/hud_pkg.sv
// Shared constants for the HUD tile map: sprite codes, converter FSM state
// codes and small constant helpers.
package hud_pkg;

    // Sprite codes understood by the tile renderer
    localparam logic [5:0] SprDigitBase  = 6'd0;
    localparam logic [5:0] SprLetterBase = 6'd11;
    localparam logic [5:0] SprBox        = 6'd37;
    localparam logic [5:0] SprEmpty      = 6'd45;

    // Converter FSM state encoding
    typedef logic [1:0] hud_state_t;
    localparam hud_state_t StIdle  = 2'd0;
    localparam hud_state_t StShift = 2'd1;
    localparam hud_state_t StLatch = 2'd2;

    // Sprite code for an upper-case ASCII letter
    function automatic logic [5:0] letter_code(input logic [7:0] c);
        logic [7:0] ofs;
        ofs = c - 8'h41;
        return SprLetterBase + ofs[5:0];
    endfunction

    // 10^n, used to size the saturation limit at elaboration
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one iteration per clock.
// start loads a snapshot of bin (and aborts any conversion in flight); done is
// high in the cycle whose closing edge performs the final iteration, so bcd
// holds the finished result from the following cycle until the next start.
module bin2bcd_seq
    import hud_pkg::*;
#(
    parameter int unsigned SCORE_W      = 20,
    parameter int unsigned SCORE_DIGITS = 6
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic [SCORE_W-1:0]        bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*SCORE_DIGITS-1:0] bcd
);

    localparam int unsigned BcdW = 4 * SCORE_DIGITS;
    localparam int unsigned SrW  = BcdW + SCORE_W;
    localparam int unsigned CntW = $clog2(SCORE_W + 1);
    localparam logic [CntW-1:0] CntInit = SCORE_W[CntW-1:0];
    localparam logic [CntW-1:0] CntOne  = 1;

    // {bcd digits, remaining binary bits}
    logic [SrW-1:0]  sr_q, sr_d, adj;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;

    // Add-3 correction on every digit that is 5 or more, ahead of the shift
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (adj[SCORE_W + 4*i +: 4] >= 4'd5) begin
                adj[SCORE_W + 4*i +: 4] = adj[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, otherwise shift one bit per cycle while busy
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            sr_d   = {{BcdW{1'b0}}, bin};
            cnt_d  = CntInit;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = {adj[SrW-2:0], 1'b0};
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
                busy_d = 1'b0;
            end
        end
    end

    // Converter state registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    // A start in the same cycle aborts, so it masks completion
    assign done = busy_q && (cnt_q == CntOne) && !start;
    assign bcd  = sr_q[SCORE_W +: BcdW];

endmodule

// File: rtl/hud_tile_map.sv
// HUD tile map: HOLD/QUEUE/SCORE labels, preview boxes and a saturating
// decimal score, rendered as one registered sprite code per screen tile.
module hud_tile_map
    import hud_pkg::*;
#(
    parameter int unsigned TILE_PX      = 20,
    parameter int unsigned SCORE_DIGITS = 6,
    parameter int unsigned SCORE_W      = 20,
    parameter int unsigned LABEL_ROW    = 4,
    parameter int unsigned SCORE_ROW    = 11
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       add_valid,
    input  logic [9:0] add_amount,
    output logic       add_ready,
    input  logic       score_clear,
    output logic [5:0] spriteindex
);

    localparam int unsigned BcdW        = 4 * SCORE_DIGITS;
    localparam int unsigned ScoreMaxInt = pow10(SCORE_DIGITS) - 1;
    localparam logic [SCORE_W:0] ScoreMax = ScoreMaxInt[SCORE_W:0];
    localparam logic [9:0] TilePx   = TILE_PX[9:0];
    localparam logic [9:0] LabelRow = LABEL_ROW[9:0];
    localparam logic [9:0] ScoreRow = SCORE_ROW[9:0];

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;
    hud_state_t         state_q, state_d;
    logic               start_q, start_d;
    logic [BcdW-1:0]    digits_q, digits_d;
    logic [BcdW-1:0]    conv_bcd;
    logic               conv_busy, conv_done;

    logic [9:0] tx, ty, col;
    logic [3:0] dig;
    logic [5:0] sprite_d;
    logic [5:0] sprite_q;

    // The converter is only ever busy outside IDLE; the extra term is a guard
    assign add_ready = (state_q == StIdle) && !conv_busy;

    // Saturating sum of the current score and the requested amount
    always_comb begin
        sum = {1'b0, score_q} + {{(SCORE_W + 1 - 10){1'b0}}, add_amount};
        if (sum > ScoreMax) begin
            sum = ScoreMax;
        end
    end

    // Score update and converter FSM; clear wins over add and over any state
    always_comb begin
        score_d  = score_q;
        state_d  = state_q;
        start_d  = 1'b0;
        digits_d = digits_q;
        if (score_clear) begin
            score_d = '0;
            state_d = StShift;
            start_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (add_valid && add_ready) begin
                        score_d = sum[SCORE_W-1:0];
                        state_d = StShift;
                        start_d = 1'b1;
                    end
                end
                StShift: begin
                    if (conv_done) begin
                        state_d = StLatch;
                    end
                end
                StLatch: begin
                    // All digits swap together, never a half-converted value
                    digits_d = conv_bcd;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Score, FSM and displayed-digit registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_q  <= '0;
            state_q  <= StIdle;
            start_q  <= 1'b0;
            digits_q <= '0;
        end else begin
            score_q  <= score_d;
            state_q  <= state_d;
            start_q  <= start_d;
            digits_q <= digits_d;
        end
    end

    // start_q fires the cycle after the score register settles, so the
    // converter snapshots the already-updated score
    bin2bcd_seq #(
        .SCORE_W      (SCORE_W),
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_bin2bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start_q),
        .bin   (score_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Displayed digit for the tile under the beam, most significant leftmost
    always_comb begin
        dig = 4'd0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (tx == 10'(14 + i)) begin
                dig = digits_q[(SCORE_DIGITS - 1 - i)*4 +: 4];
            end
        end
    end

    // Tile decode; earlier branches take priority on overlap
    always_comb begin
        tx       = DrawX / TilePx;
        ty       = DrawY / TilePx;
        col      = tx - 10'd14;
        sprite_d = SprEmpty;
        if (DrawX >= 10'd640 || DrawY >= 10'd480) begin
            sprite_d = SprEmpty;
        end else if (ty == LabelRow && tx <= 10'd3) begin
            case (tx)
                10'd0:   sprite_d = letter_code("H");
                10'd1:   sprite_d = letter_code("O");
                10'd2:   sprite_d = letter_code("L");
                default: sprite_d = letter_code("D");
            endcase
        end else if (ty == LabelRow && tx >= 10'd14 && tx <= 10'd18) begin
            case (col)
                10'd0:   sprite_d = letter_code("Q");
                10'd1:   sprite_d = letter_code("U");
                10'd2:   sprite_d = letter_code("E");
                10'd3:   sprite_d = letter_code("U");
                default: sprite_d = letter_code("E");
            endcase
        end else if (ty >= LabelRow + 10'd1 && ty <= LabelRow + 10'd4 &&
                     (tx <= 10'd3 || (tx >= 10'd14 && tx <= 10'd17))) begin
            sprite_d = SprBox;
        end else if (ty == ScoreRow && tx >= 10'd14 && tx <= 10'd18) begin
            case (col)
                10'd0:   sprite_d = letter_code("S");
                10'd1:   sprite_d = letter_code("C");
                10'd2:   sprite_d = letter_code("O");
                10'd3:   sprite_d = letter_code("R");
                default: sprite_d = letter_code("E");
            endcase
        end else if (ty == ScoreRow + 10'd1 && tx >= 10'd14 &&
                     tx < 10'(14 + SCORE_DIGITS)) begin
            sprite_d = SprDigitBase + {2'b00, dig};
        end
    end

    // Registered sprite output, one cycle behind DrawX/DrawY
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sprite_q <= SprEmpty;
        end else begin
            sprite_q <= sprite_d;
        end
    end

    assign spriteindex = sprite_q;

endmodule

// File: tb/tb_hud_tile_map.sv
// Directed bench for hud_tile_map: tile decode, score adds, saturation,
// clear/abort behaviour and reset, with a queue of expected sprite codes.
module tb_hud_tile_map;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       add_valid = 1'b0;
    logic [9:0] add_amount = '0;
    logic       add_ready;
    logic       score_clear = 1'b0;
    logic [5:0] spriteindex;

    int    checks = 0;
    int    errors = 0;
    int    model = 0;
    int    n;
    int    exp_q[$];
    string tag_q[$];

    hud_tile_map dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .add_valid   (add_valid),
        .add_amount  (add_amount),
        .add_ready   (add_ready),
        .score_clear (score_clear),
        .spriteindex (spriteindex)
    );

    always #5 Clk = ~Clk;

    // Step past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a pixel, queue its expected code, pop and compare one cycle later
    task automatic probe(input int x, input int y, input int exp, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        check(tag_q.pop_front(), {26'd0, spriteindex}, exp_q.pop_front());
    endtask

    // Count cycles until add_ready returns, bounded
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (add_ready !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("ready_bound", {31'd0, add_ready}, 1);
    endtask

    task automatic do_add(input int amt, output int lowcnt);
        check("ready_before_add", {31'd0, add_ready}, 1);
        add_valid  = 1'b1;
        add_amount = 10'(amt);
        tick();
        add_valid = 1'b0;
        wait_ready(lowcnt);
        model = (model + amt > 999999) ? 999999 : model + amt;
    endtask

    task automatic check_digits(input int value, input string tag);
        int p;
        p = 100000;
        for (int i = 0; i < 6; i++) begin
            probe(280 + 20*i, 240, (value / p) % 10, tag);
            p = p / 10;
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_ready", {31'd0, add_ready}, 1);
        check("reset_sprite", {26'd0, spriteindex}, 45);
        Reset = 1'b0;
        check_digits(0, "reset_digits");

        // Tile decode
        probe(40, 80, 22, "hold_L");
        probe(0, 80, 18, "hold_H");
        probe(300, 80, 31, "queue_U");
        probe(320, 80, 15, "queue_E");
        probe(700, 10, 45, "off_x");
        probe(100, 490, 45, "off_y");
        probe(20, 100, 37, "box_left");
        probe(340, 160, 37, "box_right");
        probe(380, 100, 45, "box_gap");
        probe(280, 220, 29, "score_S");
        probe(379, 239, 15, "score_E");
        probe(400, 240, 45, "past_digits");
        probe(639, 479, 45, "corner");

        // 1234 via two adds (add_amount is 10 bits wide)
        do_add(1000, n);
        check("add_busy_cycles", n, 22);
        do_add(234, n);
        check("add_busy_cycles2", n, 22);
        check_digits(1234, "digits_1234");

        // Clear, then climb to 999990 and saturate
        score_clear = 1'b1;
        tick();
        score_clear = 1'b0;
        wait_ready(n);
        model = 0;
        check_digits(0, "after_clear");
        while (model + 1023 <= 999990) begin
            do_add(1023, n);
        end
        do_add(999990 - model, n);
        check_digits(999990, "digits_999990");
        do_add(25, n);
        check_digits(999999, "sat_25");
        do_add(1, n);
        check_digits(999999, "sat_1");

        // Clear and add together: clear wins, add dropped
        add_valid   = 1'b1;
        add_amount  = 10'd5;
        score_clear = 1'b1;
        tick();
        add_valid   = 1'b0;
        score_clear = 1'b0;
        wait_ready(n);
        check("clear_add_cycles", n, 22);
        model = 0;
        check_digits(0, "clear_beats_add");

        // Add 500 then clear 5 cycles later: hundreds tile never shows 5
        add_valid  = 1'b1;
        add_amount = 10'd500;
        tick();
        add_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            score_clear = (k == 5);
            probe(340, 240, 0, "no_500");
        end
        score_clear = 1'b0;
        check("abort_ready", {31'd0, add_ready}, 1);
        check_digits(0, "abort_digits");

        // add_valid held through busy: 7 accepted exactly once
        add_valid  = 1'b1;
        add_amount = 10'd100;
        tick();
        add_amount = 10'd7;
        wait_ready(n);
        tick();
        add_valid = 1'b0;
        check("held_accepted", {31'd0, add_ready}, 0);
        wait_ready(n);
        check("held_busy_cycles", n, 22);
        tick();
        tick();
        check("held_once", {31'd0, add_ready}, 1);
        model = 107;
        check_digits(107, "held_digits");

        // Reset mid-SHIFT
        DrawX      = 10'd300;
        DrawY      = 10'd240;
        add_valid  = 1'b1;
        add_amount = 10'd50;
        tick();
        add_valid = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check("rst_mid_ready", {31'd0, add_ready}, 1);
        check("rst_mid_sprite", {26'd0, spriteindex}, 45);
        Reset = 1'b0;
        model = 0;
        check_digits(0, "rst_mid_digits");
        do_add(1, n);
        check_digits(1, "rst_score_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
